// File: rtl/locker_pkg.sv
// Shared state encoding, default code geometry and counter sizing for the combination locker.
// Also used by the latch-bank wrapper so both sides agree on DIGITS x DIGIT_W.
package locker_pkg;

   localparam int LOCKER_DIGITS  = 4;
   localparam int LOCKER_DIGIT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENTER,
      ST_CHECK,
      ST_OPEN,
      ST_PROG,
      ST_LOCKOUT
   } locker_state_t;

   // Counters hold their bound itself, so one extra bit beyond clog2.
   function automatic int cnt_w(input int bound);
      return $clog2(bound) + 1;
   endfunction

endpackage

// File: rtl/locker_timer.sv
// Loadable saturating down-counter; load takes effect on the next edge, done is high during the last counted cycle.
// No backpressure: load simply restarts the count.
module locker_timer
   import locker_pkg::*;
#(
   parameter int MAX_COUNT = 16
) (
   input  logic C,
   input  logic CLRn,
   input  logic load,
   output logic done
);

   localparam int W = cnt_w(MAX_COUNT);

   logic [W-1:0] cnt_q;

   always_ff @(posedge C or negedge CLRn) begin
      if (!CLRn) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= W'(MAX_COUNT);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign done = (cnt_q == W'(1));

endmodule

// File: rtl/locker_ctrl.sv
// Combination-lock sequencer: keypad entry, code check, unlock timing and latch-bank programming; lockout optional via LOCKER_LOCKOUT_EN.
// All outputs registered; OK -> UNLOCK/ALARM two edges later; strobes arriving outside their state are dropped (no backpressure).
module locker_ctrl
   import locker_pkg::*;
#(
   parameter int DIGITS         = LOCKER_DIGITS,
   parameter int DIGIT_W        = LOCKER_DIGIT_W,
   parameter int OPEN_CYCLES    = 16,
   parameter int MAX_FAIL       = 3,
   parameter int LOCKOUT_CYCLES = 64
) (
   input  logic                      C,
   input  logic                      CLRn,
   input  logic                      KEY_V,
   input  logic [DIGIT_W-1:0]        KEY,
   input  logic                      OK,
   input  logic                      SET,
   input  logic [DIGITS*DIGIT_W-1:0] LAT_Q,
   output logic [DIGIT_W-1:0]        LAT_D,
   output logic [DIGITS-1:0]         LAT_C,
   output logic                      UNLOCK,
   output logic                      ALARM,
   output logic                      BUSY
);

   localparam int               IDX_W    = cnt_w(DIGITS);
   localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(DIGITS);

   locker_state_t               state_q;
   logic [IDX_W-1:0]            idx_q;
   logic [DIGITS*DIGIT_W-1:0]   code_buf_q;
   logic                        force_miss_q;
   logic                        unlock_q;
   logic                        busy_q;
   logic [DIGIT_W-1:0]          lat_d_q;
   logic [DIGITS-1:0]           lat_c_q;

   logic                        code_ok;
   logic                        open_load;
   logic                        open_done;

   // A short entry or a bare OK can never match, even against an all-zero stored code.
   assign code_ok   = !force_miss_q && (code_buf_q == LAT_Q);
   assign open_load = (state_q == ST_CHECK) && code_ok;

   locker_timer #(
      .MAX_COUNT (OPEN_CYCLES)
   ) u_open_timer (
      .C    (C),
      .CLRn (CLRn),
      .load (open_load),
      .done (open_done)
   );

`ifdef LOCKER_LOCKOUT_EN
   localparam int FAIL_W = cnt_w(MAX_FAIL);

   logic [FAIL_W-1:0] fail_q;
   logic [FAIL_W-1:0] fail_inc;
   logic              alarm_q;
   logic              lock_trip;
   logic              lock_load;
   logic              lock_done;

   assign fail_inc  = (fail_q == '1) ? fail_q : fail_q + FAIL_W'(1);
   assign lock_trip = (fail_inc >= FAIL_W'(MAX_FAIL));
   assign lock_load = (state_q == ST_CHECK) && !code_ok && lock_trip;

   locker_timer #(
      .MAX_COUNT (LOCKOUT_CYCLES)
   ) u_lock_timer (
      .C    (C),
      .CLRn (CLRn),
      .load (lock_load),
      .done (lock_done)
   );

   assign ALARM = alarm_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^{MAX_FAIL[0], LOCKOUT_CYCLES[0]};
   assign ALARM      = 1'b0;
`endif

   always_ff @(posedge C or negedge CLRn) begin
      if (!CLRn) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         code_buf_q   <= '0;
         force_miss_q <= 1'b0;
         unlock_q     <= 1'b0;
         busy_q       <= 1'b0;
         lat_d_q      <= '0;
         lat_c_q      <= '0;
`ifdef LOCKER_LOCKOUT_EN
         fail_q       <= '0;
         alarm_q      <= 1'b0;
`endif
      end else begin
         lat_c_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (OK) begin
                  state_q      <= ST_CHECK;
                  force_miss_q <= 1'b1;
                  busy_q       <= 1'b1;
               end else if (KEY_V) begin
                  code_buf_q[DIGIT_W-1:0] <= KEY;
                  idx_q                   <= IDX_W'(1);
                  state_q                 <= ST_ENTER;
               end
            end

            ST_ENTER: begin
               if (OK) begin
                  state_q      <= ST_CHECK;
                  force_miss_q <= (idx_q < IDX_FULL);
                  busy_q       <= 1'b1;
               end else if (KEY_V && (idx_q < IDX_FULL)) begin
                  for (int i = 0; i < DIGITS; i++) begin
                     if (idx_q == IDX_W'(i)) code_buf_q[i*DIGIT_W +: DIGIT_W] <= KEY;
                  end
                  idx_q <= idx_q + IDX_W'(1);
               end
            end

            ST_CHECK: begin
               idx_q        <= '0;
               code_buf_q   <= '0;
               force_miss_q <= 1'b0;
               if (code_ok) begin
                  state_q  <= ST_OPEN;
                  unlock_q <= 1'b1;
                  busy_q   <= 1'b0;
`ifdef LOCKER_LOCKOUT_EN
                  fail_q   <= '0;
               end else if (lock_trip) begin
                  state_q  <= ST_LOCKOUT;
                  alarm_q  <= 1'b1;
                  fail_q   <= fail_inc;
               end else begin
                  state_q  <= ST_IDLE;
                  busy_q   <= 1'b0;
                  fail_q   <= fail_inc;
               end
`else
               end else begin
                  state_q  <= ST_IDLE;
                  busy_q   <= 1'b0;
               end
`endif
            end

            ST_OPEN: begin
               // SET wins over expiry so a last-cycle request still reprograms.
               if (SET) begin
                  state_q  <= ST_PROG;
                  unlock_q <= 1'b0;
                  idx_q    <= '0;
                  busy_q   <= 1'b1;
               end else if (open_done) begin
                  state_q  <= ST_IDLE;
                  unlock_q <= 1'b0;
               end
            end

            ST_PROG: begin
               // Leaving one cycle after the last key lets its enable pulse finish first.
               if (idx_q == IDX_FULL) begin
                  state_q <= ST_IDLE;
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (KEY_V) begin
                  lat_d_q <= KEY;
                  for (int i = 0; i < DIGITS; i++) begin
                     lat_c_q[i] <= (idx_q == IDX_W'(i));
                  end
                  idx_q <= idx_q + IDX_W'(1);
               end
            end

`ifdef LOCKER_LOCKOUT_EN
            ST_LOCKOUT: begin
               if (lock_done) begin
                  state_q <= ST_IDLE;
                  alarm_q <= 1'b0;
                  busy_q  <= 1'b0;
                  fail_q  <= '0;
               end
            end
`endif

            default: begin
               state_q  <= ST_IDLE;
               unlock_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign LAT_D  = lat_d_q;
   assign LAT_C  = lat_c_q;
   assign UNLOCK = unlock_q;
   assign BUSY   = busy_q;

endmodule

// File: tb/tb_locker_ctrl.sv
// Self-checking bench for locker_ctrl: randomized keypad sessions against a code/fail-count model and a clocked latch-bank model.
module tb_locker_ctrl;

   localparam int DIGITS         = 4;
   localparam int DIGIT_W        = 4;
   localparam int OPEN_CYCLES    = 16;
   localparam int MAX_FAIL       = 3;
   localparam int LOCKOUT_CYCLES = 64;
`ifdef LOCKER_LOCKOUT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic                      C = 1'b0;
   logic                      CLRn;
   logic                      KEY_V;
   logic [DIGIT_W-1:0]        KEY;
   logic                      OK;
   logic                      SET;
   logic [DIGITS*DIGIT_W-1:0] LAT_Q;
   logic [DIGIT_W-1:0]        LAT_D;
   logic [DIGITS-1:0]         LAT_C;
   logic                      UNLOCK;
   logic                      ALARM;
   logic                      BUSY;

   logic [3:0] bank [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
   logic [3:0] code_m [4];
   logic [3:0] sess [$];
   int         fails_m;
   int         n_tests;
   int         n_fail;

   locker_ctrl #(
      .DIGITS         (DIGITS),
      .DIGIT_W        (DIGIT_W),
      .OPEN_CYCLES    (OPEN_CYCLES),
      .MAX_FAIL       (MAX_FAIL),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
   ) dut (
      .C      (C),
      .CLRn   (CLRn),
      .KEY_V  (KEY_V),
      .KEY    (KEY),
      .OK     (OK),
      .SET    (SET),
      .LAT_Q  (LAT_Q),
      .LAT_D  (LAT_D),
      .LAT_C  (LAT_C),
      .UNLOCK (UNLOCK),
      .ALARM  (ALARM),
      .BUSY   (BUSY)
   );

   always #5 C = ~C;

   // Latch bank: a digit takes LAT_D when its enable is seen high at a clock edge.
   always @(posedge C) begin
      for (int i = 0; i < DIGITS; i++) begin
         if (LAT_C[i]) bank[i] <= LAT_D;
      end
   end
   assign LAT_Q = {bank[3], bank[2], bank[1], bank[0]};

   // One keypad session from the IDLE state using the keys in sess, then OK.
   task automatic attempt(input string nm, input bit hold_open, input bit key_with_ok);
      bit match;
      bit lock_exp;
      int cnt;
      foreach (sess[i]) begin
         KEY_V = 1'b1;
         KEY   = sess[i];
         @(negedge C);
         KEY_V = 1'b0;
         if ($urandom_range(0, 1) == 1) @(negedge C);
      end
      OK = 1'b1;
      if (key_with_ok) begin
         KEY_V = 1'b1;
         KEY   = 4'($urandom);
      end
      @(negedge C);
      OK    = 1'b0;
      KEY_V = 1'b0;

      match = (sess.size() >= DIGITS);
      for (int i = 0; i < DIGITS; i++) begin
         if (match && (sess[i] !== code_m[i])) match = 1'b0;
      end
      if (match) fails_m = 0;
      else fails_m++;
      lock_exp = LOCK_EN && !match && (fails_m >= MAX_FAIL);

      n_tests++;
      if ({BUSY, UNLOCK} !== 2'b10) begin
         n_fail++;
         $display("FAIL %s check-cycle: busy,unlock=%b expected 10", nm, {BUSY, UNLOCK});
      end
      @(negedge C);
      n_tests++;
      if ({UNLOCK, ALARM, BUSY} !== {match, lock_exp, lock_exp}) begin
         n_fail++;
         $display("FAIL %s verdict: unlock,alarm,busy=%b expected %b", nm,
                  {UNLOCK, ALARM, BUSY}, {match, lock_exp, lock_exp});
      end

      if (match && !hold_open) begin
         cnt = 1;
         for (int k = 0; k < 200 && UNLOCK; k++) begin
            KEY_V = 1'($urandom_range(0, 1));
            KEY   = 4'($urandom);
            OK    = 1'($urandom_range(0, 1));
            @(negedge C);
            KEY_V = 1'b0;
            OK    = 1'b0;
            if (UNLOCK) cnt++;
         end
         n_tests++;
         if (cnt != OPEN_CYCLES || UNLOCK !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL %s unlock-width: %0d cycles (unlock=%b busy=%b) expected %0d cycles then idle",
                     nm, cnt, UNLOCK, BUSY, OPEN_CYCLES);
         end
      end else if (lock_exp) begin
         cnt = 1;
         for (int k = 0; k < 400 && ALARM; k++) begin
            KEY_V = 1'($urandom_range(0, 1));
            KEY   = 4'($urandom);
            OK    = 1'($urandom_range(0, 1));
            SET   = 1'($urandom_range(0, 1));
            @(negedge C);
            KEY_V = 1'b0;
            OK    = 1'b0;
            SET   = 1'b0;
            if (ALARM) cnt++;
         end
         fails_m = 0;
         n_tests++;
         if (cnt != LOCKOUT_CYCLES || ALARM !== 1'b0 || BUSY !== 1'b0 || UNLOCK !== 1'b0) begin
            n_fail++;
            $display("FAIL %s lockout-width: %0d cycles (alarm=%b busy=%b) expected %0d cycles then idle",
                     nm, cnt, ALARM, BUSY, LOCKOUT_CYCLES);
         end
      end
   endtask

   task automatic load_correct(input int extra);
      sess.delete();
      for (int i = 0; i < DIGITS; i++) sess.push_back(code_m[i]);
      for (int i = 0; i < extra; i++) sess.push_back(4'($urandom));
   endtask

   // Programs nk while in PROG; cut_at < DIGITS drops CLRn during that digit's enable pulse.
   task automatic prog_seq(input string nm, input logic [3:0] nk [4], input int cut_at);
      int gap;
      for (int i = 0; i < DIGITS; i++) begin
         KEY_V = 1'b1;
         KEY   = nk[i];
         @(negedge C);
         KEY_V = 1'b0;
         n_tests++;
         if (LAT_C !== 4'(1 << i) || LAT_D !== nk[i] || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL %s pulse%0d: lat_c=%b lat_d=%0d busy=%b expected lat_c=%b lat_d=%0d busy=1",
                     nm, i, LAT_C, LAT_D, BUSY, 4'(1 << i), nk[i]);
         end
         if (i == cut_at) begin
            #2 CLRn = 1'b0;
            #1;
            n_tests++;
            if (LAT_C !== 4'd0 || LAT_D !== 4'd0 || {UNLOCK, ALARM, BUSY} !== 3'b000) begin
               n_fail++;
               $display("FAIL %s async-clear: lat_c=%b lat_d=%0d u,a,b=%b expected all zero",
                        nm, LAT_C, LAT_D, {UNLOCK, ALARM, BUSY});
            end
            for (int j = 0; j < i; j++) code_m[j] = nk[j];
            fails_m = 0;
            n_tests++;
            if (LAT_Q[3:0] !== nk[0]) begin
               n_fail++;
               $display("FAIL %s kept-digit0: lat_q[3:0]=%0d expected %0d", nm, LAT_Q[3:0], nk[0]);
            end
            @(negedge C);
            CLRn = 1'b1;
            return;
         end
         if (i < DIGITS - 1) begin
            gap = (i == 0) ? 0 : $urandom_range(0, 2);
            repeat (gap) begin
               OK  = 1'($urandom_range(0, 1));
               SET = 1'($urandom_range(0, 1));
               @(negedge C);
               OK  = 1'b0;
               SET = 1'b0;
               n_tests++;
               if (LAT_C !== 4'd0) begin
                  n_fail++;
                  $display("FAIL %s gap-after-%0d: lat_c=%b expected 0000", nm, i, LAT_C);
               end
            end
         end
      end
      @(negedge C);
      n_tests++;
      if (LAT_C !== 4'd0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL %s prog-exit: lat_c=%b busy=%b expected 0000 and 0", nm, LAT_C, BUSY);
      end
      for (int j = 0; j < DIGITS; j++) code_m[j] = nk[j];
   endtask

   task automatic enter_prog(input string nm, input int wait_cycles);
      load_correct(0);
      attempt({nm, "-open"}, 1'b1, 1'b0);
      repeat (wait_cycles) @(negedge C);
      SET = 1'b1;
      @(negedge C);
      SET = 1'b0;
      n_tests++;
      if ({UNLOCK, BUSY} !== 2'b01) begin
         n_fail++;
         $display("FAIL %s set: unlock,busy=%b expected 01", nm, {UNLOCK, BUSY});
      end
   endtask

   task automatic test_reset();
      CLRn  = 1'b0;
      KEY_V = 1'b0;
      KEY   = '0;
      OK    = 1'b0;
      SET   = 1'b0;
      repeat (3) @(negedge C);
      n_tests++;
      if ({UNLOCK, ALARM, BUSY, LAT_C, LAT_D} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset-held: outputs=%b expected all zero", {UNLOCK, ALARM, BUSY, LAT_C, LAT_D});
      end
      CLRn = 1'b1;
      repeat (2) @(negedge C);
      n_tests++;
      if ({UNLOCK, ALARM, BUSY, LAT_C, LAT_D} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset-released: outputs=%b expected all zero", {UNLOCK, ALARM, BUSY, LAT_C, LAT_D});
      end
   endtask

   task automatic test_unlock();
      load_correct(0);
      attempt("unlock_1234", 1'b0, 1'b0);
   endtask

   task automatic test_short_and_extra();
      sess = '{code_m[0], code_m[1]};
      attempt("short_entry", 1'b0, 1'b0);
      load_correct(1);
      attempt("fifth_key_ignored", 1'b0, 1'b0);
      sess.delete();
      attempt("bare_ok", 1'b0, 1'b0);
   endtask

   task automatic test_simultaneous();
      load_correct(0);
      attempt("key_with_ok", 1'b0, 1'b1);
   endtask

   task automatic test_wrong_codes();
      for (int r = 0; r < MAX_FAIL; r++) begin
         load_correct(0);
         sess[DIGITS-1] = code_m[DIGITS-1] + 4'd1;
         attempt($sformatf("wrong_%0d", r), 1'b0, 1'b0);
      end
      load_correct(0);
      attempt("after_wrong", 1'b0, 1'b0);
   endtask

   task automatic test_prog();
      logic [3:0] nk [4];
      nk = '{4'd9, 4'd8, 4'd7, 4'd6};
      enter_prog("prog_9876", 0);
      prog_seq("prog_9876", nk, DIGITS);
      load_correct(0);
      attempt("unlock_9876", 1'b0, 1'b0);
   endtask

   task automatic test_set_priority();
      logic [3:0] nk [4];
      foreach (nk[i]) nk[i] = 4'($urandom);
      enter_prog("set_at_expiry", OPEN_CYCLES - 1);
      prog_seq("set_at_expiry", nk, DIGITS);
      load_correct(0);
      attempt("unlock_after_expiry_set", 1'b0, 1'b0);
   endtask

   task automatic test_reset_in_prog();
      logic [3:0] nk [4];
      foreach (nk[i]) nk[i] = 4'($urandom);
      enter_prog("reset_in_prog", 0);
      prog_seq("reset_in_prog", nk, 1);
      load_correct(0);
      attempt("unlock_after_cut", 1'b0, 1'b0);
   endtask

   task automatic test_random();
      int         kind;
      int         j;
      for (int r = 0; r < 12; r++) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0: load_correct(0);
            1: load_correct($urandom_range(1, 2));
            2: begin
               load_correct(0);
               j = $urandom_range(0, DIGITS - 1);
               sess[j] = sess[j] ^ 4'($urandom_range(1, 15));
            end
            3: begin
               sess.delete();
               repeat ($urandom_range(0, DIGITS - 1)) sess.push_back(4'($urandom));
            end
            default: load_correct(0);
         endcase
         attempt($sformatf("random_%0d_kind%0d", r, kind), 1'b0,
                 (kind == 4) || ($urandom_range(0, 3) == 0));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      fails_m = 0;
      code_m  = '{4'd1, 4'd2, 4'd3, 4'd4};
      test_reset();
      test_unlock();
      test_short_and_extra();
      test_simultaneous();
      test_wrong_codes();
      test_prog();
      test_set_priority();
      test_reset_in_prog();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/locker_ctrl.md
# locker_ctrl

Sequencing controller for the combination locker. Collects keypad digits, compares the entered code against the code held in the D_EN latch bank, drives the unlock and alarm outputs, and sequences the latch enables (`LAT_C`) and shared data bus (`LAT_D`) when a new code is programmed. It sits between the keypad debouncer and the `DIGITS` × `DIGIT_W` D_EN latch bank. It is the only writer of that bank.

## Interface
- `DIGITS`, 4: code length in digits.
- `DIGIT_W`, 4: bits per digit.
- `OPEN_CYCLES`, 16: cycles `UNLOCK` stays high.
- `MAX_FAIL`, 3: consecutive wrong codes that trigger lockout.
- `LOCKOUT_CYCLES`, 64: lockout duration in cycles.

Ports:
- `C` input 1: clock, rising edge.
- `CLRn` input 1: asynchronous active-low reset.
- `KEY_V` input 1: one-cycle strobe, a digit is valid.
- `KEY` input `DIGIT_W`: digit value, sampled when `KEY_V`=1.
- `OK` input 1: one-cycle strobe, submit the entered code.
- `SET` input 1: one-cycle strobe, request reprogramming. Honoured only in OPEN.
- `LAT_Q` input `DIGITS*DIGIT_W`: stored code from the latch bank. Digit 0 is in the LSBs.
- `LAT_D` output `DIGIT_W`: shared data bus to all latches.
- `LAT_C` output `DIGITS`: per-digit latch enable, one-hot or zero.
- `UNLOCK` output 1: door release.
- `ALARM` output 1: lockout indicator.
- `BUSY` output 1: high in CHECK, PROG and LOCKOUT.

## Operation
- Reset values:
  - state IDLE.
  - `UNLOCK`, `ALARM`, `BUSY` = 0.
  - `LAT_C` = 0 and `LAT_D` = 0.
  - digit index = 0, fail count = 0, entry buffer = 0.
- States: IDLE, ENTER, CHECK, OPEN, PROG, LOCKOUT.
- IDLE:
  - `KEY_V` writes buffer[0], sets index=1 and moves to ENTER.
  - `OK` alone counts as a wrong code and moves to CHECK with a forced mismatch.
- ENTER:
  - `KEY_V` with index<`DIGITS` writes buffer[index] and increments index.
  - Further keys once index=`DIGITS` are ignored.
  - `OK` moves to CHECK.
  - A short entry (index<`DIGITS`) is a forced mismatch.
- CHECK (exactly 1 cycle):
  - Full buffer equals `LAT_Q`: go to OPEN and clear the fail count.
  - Otherwise increment the fail count, then go to LOCKOUT if it reaches `MAX_FAIL`, else IDLE.
  - On every exit, clear index and buffer.
- OPEN:
  - `UNLOCK`=1 for exactly `OPEN_CYCLES` cycles, then IDLE.
  - `SET` moves to PROG immediately, drops `UNLOCK` and sets index=0.
  - `KEY_V` and `OK` are ignored.
- PROG:
  - Each `KEY_V` loads `LAT_D`=`KEY` and pulses `LAT_C`[index] high for exactly one cycle, starting the cycle after `KEY_V`.
  - index then increments. After the `DIGITS`-th write completes, go to IDLE.
  - `LAT_D` holds its value until the next write, so data is stable across the enable's falling edge.
  - `OK` and `SET` are ignored.
- LOCKOUT:
  - `ALARM`=1 for `LOCKOUT_CYCLES` cycles. All inputs are ignored.
  - Then clear the fail count, drop `ALARM` and go to IDLE.
- Simultaneous strobes: `OK` has priority over `KEY_V`; that cycle's `KEY_V` is dropped. `SET` has priority over the `OPEN_CYCLES` expiry in the same cycle.
- Counter widths: `$clog2` of the bound plus 1. Counters saturate and never wrap.
- Reset during PROG: any latches already written keep their new digits, and the `LAT_C` pulse in flight is cut to 0 asynchronously.

## Timing
- All outputs are registered. No combinational input-to-output paths.
- `OK` at edge n: CHECK during cycle n+1. `UNLOCK` or `ALARM` rises at edge n+2.
- `UNLOCK` high for exactly `OPEN_CYCLES` clock periods.
- `KEY_V` at edge n in PROG: `LAT_D` valid and `LAT_C` high from edge n+1 to edge n+2.
- Back-to-back `KEY_V` in PROG is legal and produces consecutive one-hot pulses. `LAT_C` is never multi-hot.
- `CLRn` assertion forces every output to its reset value with no clock.

## Configuration
- `LOCKER_LOCKOUT_EN` defined:
  - LOCKOUT state, fail counter and `ALARM` are present, as described above.
- Not defined:
  - A mismatch always returns to IDLE.
  - No fail counter and no LOCKOUT state; `ALARM` is tied to 0.
  - `MAX_FAIL` and `LOCKOUT_CYCLES` are unused.

## Structure
- `locker_pkg` holds:
  - the state enum `locker_state_t`;
  - the default `DIGITS` and `DIGIT_W` constants, shared with the latch-bank wrapper.
- Sub-module `locker_timer`: a loadable down-counter with a done flag. The same module is used for the OPEN and LOCKOUT durations.

## Test plan
- Stored 1-2-3-4. Keys 1,2,3,4 then `OK` → `UNLOCK`=1 two cycles after `OK`, for 16 cycles, then IDLE.
- Keys 1,2,3,5 then `OK`, three times (MAX_FAIL=3) → `ALARM` high for 64 cycles after the third. Keys during lockout have no effect.
- In OPEN, `SET` then keys 9,8,7,6 → four single-cycle one-hot `LAT_C` pulses 0001, 0010, 0100, 1000 with `LAT_D`=9,8,7,6. Then 9,8,7,6 then `OK` unlocks.
- Keys 1,2 then `OK` → mismatch and fail count 1. Keys 1,2,3,4,7 then `OK` → unlocks, since the fifth key is ignored.
- `KEY_V` and `OK` in the same cycle after 1,2,3,4 → unlock. The extra key is not stored.
- `CLRn` low in the middle of PROG on the 2nd pulse → `LAT_C`=0 immediately, state IDLE, and `LAT_Q` keeps the first new digit.
